// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB-first over
// WIDTH clocks through one shared 1-bit full adder (two half adders + OR).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit per clock, LSB first; start is ignored
// DONE  | one-cycle completion pulse; start here begins the next op at once

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  // Sum and carry of two bits.
  assign s = x ^ y;
  assign c = x & y;

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;

  logic half_s;
  logic half_c;
  logic s_bit;
  logic full_c;
  logic carry_n;

  // Shared 1-bit full adder: operand bits first, then the running carry.
  half_adder u_ha_ab (
    .x (a_sh_q[0]),
    .y (b_sh_q[0]),
    .s (half_s),
    .c (half_c)
  );

  half_adder u_ha_cin (
    .x (half_s),
    .y (carry_q),
    .s (s_bit),
    .c (full_c)
  );

  assign carry_n = half_c | full_c;

  // Next-state, datapath sequencing and result capture.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        carry_d  = carry_n;
        res_sh_d = {s_bit, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Final bit: publish the assembled word together with the carry-out.
          sum_d   = {s_bit, res_sh_q[WIDTH-1:1]};
          cout_d  = carry_n;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit instance checked every cycle against a
// countdown model, plus a 2-bit instance checked exhaustively.

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] sum;
  logic       cout, busy, done;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic [1:0] sum2;
  logic       cout2, busy2, done2;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2),
    .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: an accepted op yields a+b after WIDTH more edges; busy for those
  // edges, then done for exactly one cycle.
  bit       m_busy = 0;
  bit       m_done = 0;
  int       m_left = 0;
  bit [8:0] m_pend = '0;
  bit [7:0] m_sum  = '0;
  bit       m_cout = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_done <= 0; m_left <= 0; m_sum <= '0; m_cout <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 0;
        m_done <= 1;
        m_sum  <= m_pend[7:0];
        m_cout <= m_pend[8];
      end
    end else if (start) begin
      m_pend <= {1'b0, a} + {1'b0, b};
      m_busy <= 1;
      m_left <= 8;
      m_done <= 0;
    end else begin
      m_done <= 0;
    end
  end

  // Per-cycle comparison of the 8-bit instance against the model.
  always @(posedge clk) begin
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("sum",  {24'd0, sum},  {24'd0, m_sum});
    chk("cout", {31'd0, cout}, {31'd0, m_cout});
  end

  // Accept one op on the next edge, then wait for done; returns edges after E0.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, output int lat);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(lat);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #2;
      if (done) begin lat = k; break; end
    end
    if (lat < 0) begin
      chk_cnt++;
      $display("FAIL done_timeout: got none expected done within 20 cycles");
    end
  endtask

  initial begin
    int lat;
    int lat2;
    logic [2:0] exp3;

    #2;
    chk("rst_sum",  {24'd0, sum}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;

    // 1: 0F+01
    run_op(8'h0F, 8'h01, lat);
    chk("t1_lat", lat, 8);
    chk("t1_sum", {24'd0, sum}, 32'h10);
    chk("t1_cout", {31'd0, cout}, 32'h0);

    // 2: carry out cases
    @(posedge clk); #2;
    run_op(8'hFF, 8'h01, lat);
    chk("t2a_sum", {24'd0, sum}, 32'h00);
    chk("t2a_cout", {31'd0, cout}, 32'h1);
    @(posedge clk); #2;
    run_op(8'hFF, 8'hFF, lat);
    chk("t2b_sum", {24'd0, sum}, 32'hFE);
    chk("t2b_cout", {31'd0, cout}, 32'h1);

    // 3: start during RUN ignored, operand changes ignored
    @(posedge clk); #2;
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #2;                  // E0
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;  // after E2
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #2;                  // after E3
    start = 1'b0;
    chk("t3_sum_hold", {24'd0, sum}, 32'hFE);
    wait_done(lat);
    chk("t3_lat", lat, 5);
    chk("t3_sum", {24'd0, sum}, 32'h46);
    chk("t3_cout", {31'd0, cout}, 32'h0);

    // 4: reset mid-RUN clears outputs immediately
    @(posedge clk); #2;
    a = 8'h0F; b = 8'hF0; start = 1'b1;
    @(posedge clk); #2;                  // E0
    start = 1'b0;
    repeat (4) @(posedge clk);           // E4
    #2 reset = 1'b1;
    #1;
    chk("t4_rst_sum", {24'd0, sum}, 32'h0);
    chk("t4_rst_cout", {31'd0, cout}, 32'h0);
    chk("t4_rst_busy", {31'd0, busy}, 32'h0);
    chk("t4_rst_done", {31'd0, done}, 32'h0);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2;
    run_op(8'h80, 8'h80, lat);
    chk("t4_sum", {24'd0, sum}, 32'h00);
    chk("t4_cout", {31'd0, cout}, 32'h1);

    // 5: start held through DONE -> back-to-back ops, done pulses 9 apart
    @(posedge clk); #2;
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk); #2;                  // E0, start stays high
    a = 8'h01; b = 8'h02;
    wait_done(lat);
    chk("t5_lat1", lat, 8);
    chk("t5_sum1", {24'd0, sum}, 32'h30);
    lat2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #2;
      if (k == 1) begin
        start = 1'b0;
        chk("t5_busy_no_idle", {31'd0, busy}, 32'h1);
      end
      if (done) begin lat2 = k; break; end
    end
    chk("t5_gap", lat2, 9);
    chk("t5_sum2", {24'd0, sum}, 32'h03);

    // 6: WIDTH=2 exhaustive
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a2 = 2'(i); b2 = 2'(j); start2 = 1'b1;
        @(posedge clk); #2;
        start2 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
          @(posedge clk); #2;
          if (done2) begin lat = k; break; end
        end
        exp3 = 3'(i + j);
        chk("w2_lat", lat, 2);
        chk("w2_res", {29'd0, cout2, sum2}, {29'd0, exp3});
      end
    end

    repeat (3) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
